// File: rtl/instr_encoder.sv
// RV32I instruction encoder feeding a 2-entry valid/ready FIFO with address tagging.
// Optional build macro IMM_RANGE_CHECK_EN drops requests whose immediate does not fit the format.
module instr_encoder #(
  parameter int          ADDR_W    = 12,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [2:0]        in_funct3,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  input  logic              addr_clr,
  output logic              err_o
);

  typedef enum logic [2:0] {
    FMT_I     = 3'd0,
    FMT_S     = 3'd1,
    FMT_SB    = 3'd2,
    FMT_UJ    = 3'd3,
    FMT_JALR  = 3'd4,
    FMT_U     = 3'd5,
    FMT_AUIPC = 3'd6,
    FMT_ILL   = 3'd7
  } fmt_e;

  fmt_e              fmt;
  logic [31:0]       enc;
  logic              imm_ok;
  logic              accept;
  logic              push;
  logic              pop;
  logic [31:0]       mem [2];
  logic              rptr;
  logic              wptr;
  logic [1:0]        count;
  logic [ADDR_W-1:0] addr;

  assign fmt = fmt_e'(in_fmt);

  // NOTE: default assignment first so every path drives enc and no latch is inferred.
  always_comb begin
    enc = '0;
    unique case (fmt)
      FMT_I:     enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
      FMT_JALR:  enc = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
      FMT_S:     enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
      FMT_SB:    enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                        in_imm[4:1], in_imm[11], 7'b1100011};
      FMT_UJ:    enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
      FMT_U:     enc = {in_imm[31:12], in_rd, 7'b0110111};
      FMT_AUIPC: enc = {in_imm[31:12], in_rd, 7'b0010111};
      default:   enc = '0;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  logic signed [31:0] simm;
  assign simm = $signed(in_imm);

  always_comb begin
    imm_ok = 1'b1;
    unique case (fmt)
      FMT_I, FMT_S, FMT_JALR: imm_ok = (simm >= -32'sd2048) && (simm <= 32'sd2047);
      FMT_SB:    imm_ok = (simm >= -32'sd4096) && (simm <= 32'sd4094) && !in_imm[0];
      FMT_UJ:    imm_ok = (simm >= -32'sd1048576) && (simm <= 32'sd1048574) && !in_imm[0];
      FMT_U, FMT_AUIPC: imm_ok = (in_imm[11:0] == 12'd0);
      default:   imm_ok = 1'b1;
    endcase
  end
`else
  assign imm_ok = 1'b1;
`endif

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && (fmt != FMT_ILL) && imm_ok;
  assign pop       = out_valid && out_ready;
  assign out_addr  = addr;
  // Gating the head keeps out_instr at zero whenever the FIFO is empty.
  assign out_instr = out_valid ? mem[rptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      rptr  <= 1'b0;
      wptr  <= 1'b0;
      addr  <= ADDR_W'(BASE_ADDR);
      err_o <= 1'b0;
    end else begin
      err_o <= accept && !((fmt != FMT_ILL) && imm_ok);
      if (addr_clr) begin
        count <= '0;
        rptr  <= 1'b0;
        wptr  <= 1'b0;
        addr  <= ADDR_W'(BASE_ADDR);
      end else begin
        if (push) wptr <= ~wptr;
        if (pop) begin
          rptr <= ~rptr;
          addr <= addr + ADDR_W'(4);
        end
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  // NOTE: storage is not reset; occupancy is tracked by count and the head is gated.
  always_ff @(posedge clk) begin
    if (push && !addr_clr) mem[wptr] <= enc;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized traffic
// checked by a queue-based reference model.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_fmt = '0;
  logic [2:0]  in_funct3 = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [11:0] out_addr;
  logic        addr_clr = 1'b0;
  logic        err_o;

  int total = 0;
  int bad = 0;

  instr_encoder #(.ADDR_W(12), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_funct3(in_funct3), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .addr_clr(addr_clr), .err_o(err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] f(input logic [31:0] v, input int lo, input int width, input int pos);
    return ((v >> lo) & ((32'd1 << width) - 32'd1)) << pos;
  endfunction

  // Reference encoding built from the field-placement table with shifts and masks.
  function automatic logic [31:0] enc_ref(input logic [2:0] fmt, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [31:0] imm);
    logic [31:0] regs;
    regs = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12);
    case (fmt)
      3'd0: return f(imm, 0, 12, 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'h13;
      3'd4: return f(imm, 0, 12, 20) | (32'(rs1) << 15) | (32'(rd) << 7) | 32'h67;
      3'd1: return f(imm, 5, 7, 25) | regs | f(imm, 0, 5, 7) | 32'h23;
      3'd2: return f(imm, 12, 1, 31) | f(imm, 5, 6, 25) | regs | f(imm, 1, 4, 8)
                   | f(imm, 11, 1, 7) | 32'h63;
      3'd3: return f(imm, 20, 1, 31) | f(imm, 1, 10, 21) | f(imm, 11, 1, 20)
                   | f(imm, 12, 8, 12) | (32'(rd) << 7) | 32'h6F;
      3'd5: return (imm & 32'hFFFF_F000) | (32'(rd) << 7) | 32'h37;
      3'd6: return (imm & 32'hFFFF_F000) | (32'(rd) << 7) | 32'h17;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit legal_ref(input logic [2:0] fmt, input logic [31:0] imm);
    int s;
    s = int'($signed(imm));
    if (fmt == 3'd7) return 1'b0;
`ifdef IMM_RANGE_CHECK_EN
    case (fmt)
      3'd0, 3'd1, 3'd4: return (s >= -2048) && (s <= 2047);
      3'd2: return (s >= -4096) && (s <= 4094) && (s % 2 == 0);
      3'd3: return (s >= -1048576) && (s <= 1048574) && (s % 2 == 0);
      default: return (imm % 4096) == 0;
    endcase
`else
    return (s == s);
`endif
  endfunction

  // Reference model: queue of pending words, expected tag counter and error pulse.
  logic [31:0] exp_q[$];
  int unsigned exp_addr = 0;
  bit          exp_err = 1'b0;

  always begin
    bit acc;
    @(negedge clk);
    #2;
    if (!rst_n) begin
      exp_q.delete();
      exp_addr = 0;
      exp_err  = 1'b0;
    end else begin
      total++;
      if (out_valid !== (exp_q.size() != 0)) begin
        bad++;
        $display("FAIL mon_valid: got %b want %b at %0t", out_valid, exp_q.size() != 0, $time);
      end
      total++;
      if (in_ready !== (exp_q.size() < 2)) begin
        bad++;
        $display("FAIL mon_ready: got %b want %b at %0t", in_ready, exp_q.size() < 2, $time);
      end
      total++;
      if (out_addr !== 12'(exp_addr)) begin
        bad++;
        $display("FAIL mon_addr: got %h want %h at %0t", out_addr, 12'(exp_addr), $time);
      end
      total++;
      if (err_o !== exp_err) begin
        bad++;
        $display("FAIL mon_err: got %b want %b at %0t", err_o, exp_err, $time);
      end
      if (exp_q.size() != 0) begin
        total++;
        if (out_instr !== exp_q[0]) begin
          bad++;
          $display("FAIL mon_instr: got %h want %h at %0t", out_instr, exp_q[0], $time);
        end
      end
      acc = in_valid && (exp_q.size() < 2);
      exp_err = acc && !legal_ref(in_fmt, in_imm);
      if (addr_clr) begin
        exp_q.delete();
        exp_addr = 0;
      end else begin
        if (out_ready && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          exp_addr = (exp_addr + 4) % 4096;
        end
        if (acc && legal_ref(in_fmt, in_imm))
          exp_q.push_back(enc_ref(in_fmt, in_funct3, in_rd, in_rs1, in_rs2, in_imm));
      end
    end
  end

  task automatic set_req(input logic [2:0] fm, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    in_fmt = fm; in_funct3 = f3; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  // Drives one request until accepted; in_valid drops just after the accepting edge.
  task automatic send(input logic [2:0] fm, input logic [2:0] f3, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    bit done = 1'b0;
    @(negedge clk);
    set_req(fm, f3, rd, rs1, rs2, imm);
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL send_timeout: request fmt=%0d never accepted", fm);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total += 5;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    if (out_addr !== 12'h000) begin bad++; $display("FAIL reset_addr: got %h want 000", out_addr); end
    if (err_o !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err_o); end
    if (out_instr !== 32'h0) begin bad++; $display("FAIL reset_instr: got %h want 0", out_instr); end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    send(3'd0, 3'd0, 5'd3, 5'd0, 5'd0, 32'd7);
    send(3'd0, 3'd0, 5'd4, 5'd0, 5'd0, 32'd8);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total += 2;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL midreset_valid: got %b want 0", out_valid); end
    if (out_instr !== 32'h0) begin bad++; $display("FAIL midreset_instr: got %h want 0", out_instr); end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(2);
  endtask

  task automatic test_itype();
    out_ready = 1'b1;
    send(3'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    @(negedge clk);
    total += 3;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL addi_valid: got %b want 1", out_valid); end
    if (out_instr !== 32'h0050_0093) begin bad++; $display("FAIL addi_instr: got %h want 00500093", out_instr); end
    if (out_addr !== 12'h000) begin bad++; $display("FAIL addi_addr: got %h want 000", out_addr); end
  endtask

  task automatic test_branch_jump();
    out_ready = 1'b1;
    send(3'd2, 3'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8);
    @(negedge clk);
    total++;
    if (out_instr !== 32'hFE20_8CE3) begin bad++; $display("FAIL beq_instr: got %h want FE208CE3", out_instr); end
    send(3'd3, 3'd0, 5'd1, 5'd0, 5'd0, 32'd16);
    @(negedge clk);
    total++;
    if (out_instr !== 32'h0100_00EF) begin bad++; $display("FAIL jal_instr: got %h want 010000EF", out_instr); end
    idle(2);
  endtask

  task automatic test_back_to_back();
    logic [31:0] w[3];
    logic [31:0] gi[3];
    logic [11:0] ga[3];
    int got = 0;
    w[0] = enc_ref(3'd0, 3'd0, 5'd2, 5'd0, 5'd0, 32'd1);
    w[1] = enc_ref(3'd0, 3'd0, 5'd3, 5'd0, 5'd0, 32'd2);
    w[2] = enc_ref(3'd0, 3'd0, 5'd4, 5'd0, 5'd0, 32'd3);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0; addr_clr = 1'b1;
    @(negedge clk);
    addr_clr = 1'b0;
    set_req(3'd0, 3'd0, 5'd2, 5'd0, 5'd0, 32'd1);
    in_valid = 1'b1;
    @(negedge clk);
    set_req(3'd0, 3'd0, 5'd3, 5'd0, 5'd0, 32'd2);
    @(negedge clk);
    set_req(3'd0, 3'd0, 5'd4, 5'd0, 5'd0, 32'd3);
    repeat (3) begin
      total += 2;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready: got %b want 0", in_ready); end
      if (out_instr !== w[0]) begin bad++; $display("FAIL bp_head: got %h want %h", out_instr, w[0]); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 12 && got < 3; cyc++) begin
      if (out_valid) begin
        gi[got] = out_instr;
        ga[got] = out_addr;
        got++;
      end
      if (in_valid && in_ready) begin
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
      end else begin
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    total++;
    if (got != 3) begin bad++; $display("FAIL bp_count: got %0d words want 3", got); end
    for (int i = 0; i < got; i++) begin
      total += 2;
      if (gi[i] !== w[i]) begin bad++; $display("FAIL bp_word%0d: got %h want %h", i, gi[i], w[i]); end
      if (ga[i] !== 12'(4 * i)) begin bad++; $display("FAIL bp_addr%0d: got %h want %h", i, ga[i], 12'(4 * i)); end
    end
    idle(2);
  endtask

  task automatic test_addr_clr();
    logic [31:0] wn;
    out_ready = 1'b1;
    send(3'd0, 3'd0, 5'd5, 5'd0, 5'd0, 32'd9);
    idle(2);
    out_ready = 1'b0;
    send(3'd1, 3'd2, 5'd0, 5'd6, 5'd7, 32'd40);
    send(3'd5, 3'd0, 5'd8, 5'd0, 5'd0, 32'h1234_5000);
    @(negedge clk);
    total += 2;
    if (out_addr !== 12'h010) begin bad++; $display("FAIL clr_pre_addr: got %h want 010", out_addr); end
    if (in_ready !== 1'b0) begin bad++; $display("FAIL clr_pre_ready: got %b want 0", in_ready); end
    set_req(3'd0, 3'd0, 5'd9, 5'd0, 5'd0, 32'd1);
    in_valid = 1'b1; addr_clr = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; addr_clr = 1'b0;
    total += 3;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL clr_valid: got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin bad++; $display("FAIL clr_ready: got %b want 1", in_ready); end
    if (out_addr !== 12'h000) begin bad++; $display("FAIL clr_addr: got %h want 000", out_addr); end
    send(3'd0, 3'd0, 5'd10, 5'd0, 5'd0, 32'd2);
    @(negedge clk);
    set_req(3'd0, 3'd0, 5'd11, 5'd0, 5'd0, 32'd3);
    in_valid = 1'b1; addr_clr = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; addr_clr = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL clr_push_discard: got %b want 0", out_valid); end
    out_ready = 1'b1;
    wn = enc_ref(3'd6, 3'd0, 5'd12, 5'd0, 5'd0, 32'hABCD_E000);
    send(3'd6, 3'd0, 5'd12, 5'd0, 5'd0, 32'hABCD_E000);
    @(negedge clk);
    total += 2;
    if (out_instr !== wn) begin bad++; $display("FAIL clr_next_instr: got %h want %h", out_instr, wn); end
    if (out_addr !== 12'h000) begin bad++; $display("FAIL clr_next_addr: got %h want 000", out_addr); end
    idle(2);
  endtask

  task automatic test_illegal_range();
    out_ready = 1'b1;
    send(3'd7, 3'd0, 5'd1, 5'd0, 5'd0, 32'd0);
    @(negedge clk);
    total += 2;
    if (err_o !== 1'b1) begin bad++; $display("FAIL ill_err: got %b want 1", err_o); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL ill_valid: got %b want 0", out_valid); end
    @(negedge clk);
    total++;
    if (err_o !== 1'b0) begin bad++; $display("FAIL ill_err_clear: got %b want 0", err_o); end
    send(3'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd4096);
    @(negedge clk);
    total += 2;
`ifdef IMM_RANGE_CHECK_EN
    if (err_o !== 1'b1) begin bad++; $display("FAIL range_err: got %b want 1", err_o); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL range_valid: got %b want 0", out_valid); end
`else
    if (err_o !== 1'b0) begin bad++; $display("FAIL range_err: got %b want 0", err_o); end
    if (out_instr !== 32'h0000_0093) begin bad++; $display("FAIL range_instr: got %h want 00000093", out_instr); end
`endif
    idle(2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      logic [31:0] imm;
      @(negedge clk);
      case ($urandom_range(0, 3))
        0: imm = $urandom;
        1: imm = 32'($signed(12'($urandom)));
        2: imm = 32'($signed(14'($urandom)));
        default: imm = {$urandom_range(0, 1) ? 20'($urandom) : 20'h0, 12'h000};
      endcase
      set_req(3'($urandom_range(0, 7)), 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), imm);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      addr_clr  = ($urandom_range(0, 31) == 0);
    end
    @(negedge clk);
    in_valid = 1'b0; addr_clr = 1'b0; out_ready = 1'b1;
    idle(4);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rand_drain: got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_itype();
    test_branch_jump();
    test_back_to_back();
    test_addr_clr();
    test_illegal_range();
    test_reset_midflight();
    test_random();
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Inverse of the immediate decoder. Packs format, register fields, funct3 and a 32-bit immediate into one RV32I instruction word. Encoded words enter a 2-entry output FIFO with valid/ready on both sides. Each word is tagged with a word-aligned instruction-memory address, so the block can drive a program-load path into instruction memory.

Parameters:
ADDR_W, 12, width of out_addr (byte address; wraps modulo 2^ADDR_W)
BASE_ADDR, 0, value loaded into the address counter on reset and on addr_clr (must be a multiple of 4)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input request valid
in_ready  out  1  block can accept a request this cycle
in_fmt  in  3  0=I, 1=S, 2=SB, 3=UJ, 4=JALR, 5=U, 6=AUIPC, 7=illegal
in_funct3  in  3  funct3 field (ignored for UJ/U/AUIPC; forced 000 for JALR)
in_rd  in  5  destination register
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2
in_imm  in  32  immediate, two's complement, byte offset for SB/UJ
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head
out_instr  out  32  encoded instruction at FIFO head
out_addr  out  ADDR_W  address tagged to FIFO head
addr_clr  in  1  synchronous: flush FIFO, reload address counter
err_o  out  1  one-cycle pulse: request dropped

Behaviour:
- Reset (async, rst_n=0): FIFO empty, out_valid=0, out_instr=0, address counter=BASE_ADDR, err_o=0. in_ready=1 once reset is released.
- Accept: request is accepted when in_valid && in_ready. The encoding is combinational and is written to the FIFO tail on that edge.
- Latency: accept in cycle N with FIFO empty gives out_valid=1 in cycle N+1.
- in_ready = (FIFO count < 2). It derives from registered count only; there is no combinational path from out_ready.
- Simultaneous push and pop with count=2 is not possible, because in_ready=0. Simultaneous push and pop with count=1 leaves count=1.
- Pop: on out_valid && out_ready. The address counter advances by 4, wrapping at 2^ADDR_W.
- out_addr = current counter value. The tag is assigned when the word leaves the FIFO, not when it enters.
- Encodings (opcode in [6:0]):
  - I: {imm[11:0], rs1, funct3, rd, 0010011}
  - JALR: {imm[11:0], rs1, 000, rd, 1100111}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], 0100011}
  - SB: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 1100011}
  - UJ: {imm[20], imm[10:1], imm[11], imm[19:12], rd, 1101111}
  - U: {imm[31:12], rd, 0110111}
  - AUIPC: {imm[31:12], rd, 0010111}
- Immediate bits not listed are discarded, unless the optional range check is compiled in.
- in_fmt=7: request is accepted (handshake completes), nothing is written, and err_o pulses in the cycle after acceptance. This applies with or without the macro.
- addr_clr=1: FIFO emptied and counter set to BASE_ADDR on that edge.
  - addr_clr wins over a simultaneous push or pop in the same cycle: the pushed word is discarded and the counter does not advance.
  - in_ready=1 in the next cycle.
- Reset mid-transfer: all FIFO contents are lost immediately. No partial words are emitted.

Optional Feature:
IMM_RANGE_CHECK_EN
- Defined: before write, the immediate is checked per format:
  - I, S, JALR: -2048..2047.
  - SB: -4096..4094 and even.
  - UJ: -1048576..1048574 and even.
  - U, AUIPC: imm[11:0]==0.
- A failing request is still accepted but not written, and err_o pulses one cycle later.
- Undefined: no check; out-of-range bits are truncated per the encoding table, and err_o fires only for in_fmt=7.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, release -> out_valid=0, in_ready=1, out_addr=BASE_ADDR (0), err_o=0.
- I-type addi x1,x0,5: fmt=0, rd=1, rs1=0, funct3=0, imm=5, out_ready=1 -> next cycle out_valid=1, out_instr=0x00500093, out_addr=0x000.
- SB beq x1,x2,-8: fmt=2, rs1=1, rs2=2, funct3=0, imm=0xFFFFFFF8 -> out_instr=0xFE208CE3. UJ jal x1,16: fmt=3, rd=1, imm=16 -> out_instr=0x010000EF.
- Backpressure: out_ready=0, three back-to-back valid I-type requests -> first two accepted, in_ready=0 from the cycle after the 2nd accept, third held. Then out_ready=1 -> three words in order with out_addr 0x000, 0x004, 0x008.
- addr_clr: two words pending with counter at 0x010, assert addr_clr with in_valid=1 -> next cycle out_valid=0, in_ready=1; pushed word discarded; next emitted word has out_addr=0x000.
- Range/illegal: fmt=7 -> no output, err_o=1 for exactly one cycle. I-type imm=4096, rd=1:
  - With IMM_RANGE_CHECK_EN: dropped, err_o pulse.
  - Without: out_instr=0x00000093, no err_o.
